regfile_write_scheduler: RTL

Owns the single write port of the 32 x 64-bit register file and schedules every write to it. After reset it zeroes all registers with a hardware sweep. It then arbitrates between the pipeline writeback stage and a debug/loader write port. It sits between WB (plus the debug/loader port) and the register file's RegWrite/RD/WriteData inputs.

---
 rtl/regfile_write_scheduler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_write_scheduler.sv
// Write-port scheduler for the 32 x 64-bit register file: post-reset zero sweep, then WB/debug arbitration.
// Optional macro WSCHED_CLEAR_EN enables the CLEAR sweep FSM; without it the block starts directly in RUN.
module regfile_write_scheduler #(
  parameter int DATA_W       = 64,
  parameter int ADDR_W       = 5,
  parameter int NREGS        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ready,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_rd,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_gnt,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_busy
);

  localparam int SW = 4;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || NREGS < 1 || NREGS > (1 << ADDR_W)) begin : g_bad_cfg
    $error("regfile_write_scheduler: illegal STARVE_LIMIT or NREGS");
  end

  logic              run;
  logic              clearing;
  logic              preempt;
  logic              wb_acc;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rf_we_d;
  logic [ADDR_W-1:0] rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_d;

`ifdef WSCHED_CLEAR_EN
  typedef enum logic {CLEAR, RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == CLEAR) begin
      clr_d = clr_q + 1'b1;
      if (clr_q == ADDR_W'(NREGS - 1)) state_d = RUN;
    end
  end

  always_comb begin
    init_busy = (state_q == CLEAR);
    clearing  = (state_q == CLEAR);
    run       = (state_q == RUN);
  end
`else
  // No sweep: grants are live as soon as reset is released.
  always_comb begin
    init_busy = 1'b0;
    clearing  = 1'b0;
    run       = !reset;
  end
`endif

  always_comb begin
    preempt  = dbg_req && (starve_q == SW'(STARVE_LIMIT));
    dbg_gnt  = run && dbg_req && (!wb_valid || preempt);
    wb_ready = run && !preempt;
    wb_acc   = wb_valid && wb_ready;
  end

  // Grants are mutually exclusive, so at most one source feeds the write port per cycle.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd;
    rf_wdata_d = rf_wdata;
    if (clearing) begin
      rf_we_d    = 1'b1;
`ifdef WSCHED_CLEAR_EN
      rf_rd_d    = clr_q;
`endif
      rf_wdata_d = '0;
    end else if (dbg_gnt) begin
      rf_we_d    = (dbg_rd != '0);
      rf_rd_d    = dbg_rd;
      rf_wdata_d = dbg_data;
    end else if (wb_acc) begin
      rf_we_d    = (wb_rd != '0);
      rf_rd_d    = wb_rd;
      rf_wdata_d = wb_data;
    end
  end

  always_comb begin
    starve_d = '0;
    if (dbg_req && !dbg_gnt) begin
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      starve_q <= starve_d;
      rf_we    <= rf_we_d;
      rf_rd    <= rf_rd_d;
      rf_wdata <= rf_wdata_d;
    end
  end

endmodule
